// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the multicycle ALU control sequencer: funct codes,
// alu_op classes, ALU select codes and the sequencer state encoding.
package alu_ctrl_pkg;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [1:0] AOP_MEM   = 2'b00;
    localparam logic [1:0] AOP_BR    = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;

    localparam logic [2:0] SEL_AND  = 3'b000;
    localparam logic [2:0] SEL_OR   = 3'b001;
    localparam logic [2:0] SEL_ADD  = 3'b010;
    localparam logic [2:0] SEL_SLT  = 3'b011;
    localparam logic [2:0] SEL_ADDU = 3'b100;
    localparam logic [2:0] SEL_SLL  = 3'b101;
    localparam logic [2:0] SEL_SUB  = 3'b110;
    localparam logic [2:0] SEL_SLTU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of alu_op/funct into an ALU select code plus
// shift and legality flags. Unrecognised requests decode to AND.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 2,
    parameter int SEL_W   = 3
) (
    input  logic [FUNCT_W-1:0] funct,
    input  logic [ALUOP_W-1:0] alu_op,
    output logic [SEL_W-1:0]   sel,
    output logic               is_shift,
    output logic               is_legal
);

    always_comb begin
        sel      = SEL_AND;
        is_shift = 1'b0;
        is_legal = 1'b1;
        case (alu_op)
            AOP_MEM: sel = SEL_ADD;
            AOP_BR:  sel = SEL_SUB;
            AOP_RTYPE: begin
                case (funct)
                    FN_ADD:  sel = SEL_ADD;
                    FN_ADDU: sel = SEL_ADDU;
                    FN_SUB:  sel = SEL_SUB;
                    FN_SUBU: sel = SEL_SUB;
                    FN_AND:  sel = SEL_AND;
                    FN_OR:   sel = SEL_OR;
                    FN_SLT:  sel = SEL_SLT;
                    FN_SLTU: sel = SEL_SLTU;
                    FN_SLL: begin
                        sel      = SEL_SLL;
                        is_shift = 1'b1;
                    end
                    default: is_legal = 1'b0;
                endcase
            end
            default: is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// Multicycle ALU control sequencer: issues decoded select codes as beats,
// expanding SLL into shamt 1-bit shifts. Macro ALU_CTRL_ILLEGAL_TRAP_EN traps bad ops.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 2,
    parameter int SEL_W   = 3,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   sel,
    output logic               shift_en,
    output logic               last,
    output logic               illegal
);

    state_t             state, state_n;
    logic               out_valid_n, shift_en_n, last_n;
    logic [SEL_W-1:0]   sel_n;
    logic [SHAMT_W-1:0] count, count_n;
    logic [SEL_W-1:0]   dec_sel;
    logic               dec_shift, dec_legal;
    logic               accept, beat_done, last_done;

    alu_ctrl_decode #(
        .FUNCT_W(FUNCT_W),
        .ALUOP_W(ALUOP_W),
        .SEL_W  (SEL_W)
    ) u_decode (
        .funct   (funct),
        .alu_op  (alu_op),
        .sel     (dec_sel),
        .is_shift(dec_shift),
        .is_legal(dec_legal)
    );

    // Completing the final beat counts as returning to IDLE, so the next
    // request can be taken on that same edge without a bubble.
    assign beat_done = out_valid && out_ready;
    assign last_done = beat_done && last;
    assign in_ready  = ((state == IDLE) && !out_valid) || last_done;
    assign accept    = in_valid && in_ready;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_n;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        out_valid_n = out_valid;
        sel_n       = sel;
        shift_en_n  = shift_en;
        last_n      = last;
        count_n     = count;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        illegal_n   = 1'b0;
`endif
        case (state)
            ISSUE: begin
                if (beat_done) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b0;
                    last_n      = 1'b0;
                end
            end
            SHIFT: begin
                if (beat_done) begin
                    if (last) begin
                        state_n     = IDLE;
                        out_valid_n = 1'b0;
                        shift_en_n  = 1'b0;
                        last_n      = 1'b0;
                        count_n     = '0;
                    end else begin
                        count_n = count - SHAMT_W'(1);
                        last_n  = (count == SHAMT_W'(2));
                    end
                end
            end
            default: ;
        endcase

        if (accept) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            if (!dec_legal) begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
                shift_en_n  = 1'b0;
                last_n      = 1'b0;
                count_n     = '0;
                illegal_n   = 1'b1;
            end else
`endif
            if (dec_shift && (shamt != '0)) begin
                state_n     = SHIFT;
                out_valid_n = 1'b1;
                sel_n       = SEL_SLL;
                shift_en_n  = 1'b1;
                last_n      = (shamt == SHAMT_W'(1));
                count_n     = shamt;
            end else begin
                state_n     = ISSUE;
                out_valid_n = 1'b1;
                sel_n       = dec_legal ? dec_sel : SEL_AND;
                shift_en_n  = 1'b0;
                last_n      = 1'b1;
                count_n     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sel       <= '0;
            shift_en  <= 1'b0;
            last      <= 1'b0;
            count     <= '0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            out_valid <= out_valid_n;
            sel       <= sel_n;
            shift_en  <= shift_en_n;
            last      <= last_n;
            count     <= count_n;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_n;
`endif
        end
    end

endmodule
